// File: rtl/vid_lockstep_cmp.sv
`default_nettype none
// ============================================================================
// vid_lockstep_cmp : aligns two ce-sampled video streams on VSync and compares
//                    them word by word, logging the first mismatch.
// Rev 1.0
// ============================================================================
module vid_lockstep_cmp #(
    parameter int PIX_W    = 3,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 16,
    parameter int MAX_SKEW = 12
) (
    input  logic                         clk_sys,
    input  logic                         nRESET,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [CHANNELS*PIX_W+1:0]    cmp_mask,
    input  logic                         a_ce,
    input  logic                         b_ce,
    input  logic                         a_hs,
    input  logic                         a_vs,
    input  logic                         b_hs,
    input  logic                         b_vs,
    input  logic [CHANNELS*PIX_W-1:0]    a_pix,
    input  logic [CHANNELS*PIX_W-1:0]    b_pix,
    output logic                         locked,
    output logic                         mismatch,
    output logic [15:0]                  mism_count,
    output logic [15:0]                  frame_count,
    output logic                         first_valid,
    output logic [9:0]                   first_x,
    output logic [9:0]                   first_y,
    output logic [CHANNELS*PIX_W+1:0]    first_a,
    output logic [CHANNELS*PIX_W+1:0]    first_b,
    output logic                         overflow
);
    localparam int W  = CHANNELS*PIX_W + 2;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {SYNC = 1'b0, RUN = 1'b1} state_t;

    state_t         state, state_nx;
    logic           prev_vs_a, prev_vs_b, armed_a, armed_b;
    logic           arm_a, arm_b, armed_a_nx, armed_b_nx;
    logic           push_a, push_b, pop, fault, flush, cmp_fire;
    logic [W-1:0]   mem_a [DEPTH];
    logic [W-1:0]   mem_b [DEPTH];
    logic [AW:0]    wp_a, rp_a, wp_b, rp_b, occ_a, occ_b, skew;
    logic           empty_a, empty_b, full_a, full_b;
    logic [W-1:0]   rd_a, rd_b;
    logic           is_mism, pa_vs, pa_hs, frame_inc;
    logic [9:0]     x, y, x_nx, y_nx;

    assign occ_a   = wp_a - rp_a;
    assign occ_b   = wp_b - rp_b;
    assign empty_a = (occ_a == '0);
    assign empty_b = (occ_b == '0);
    assign full_a  = (occ_a == (AW+1)'(DEPTH));
    assign full_b  = (occ_b == (AW+1)'(DEPTH));
    assign skew    = (occ_a > occ_b) ? (occ_a - occ_b) : (occ_b - occ_a);

    // A stream arms on its own VSync rising edge; the edge sample is pushed too
    assign arm_a  = a_ce & a_vs & ~prev_vs_a;
    assign arm_b  = b_ce & b_vs & ~prev_vs_b;
    assign push_a = enable & a_ce & (armed_a | arm_a);
    assign push_b = enable & b_ce & (armed_b | arm_b);

    assign fault  = enable & ((push_a & full_a & ~pop) | (push_b & full_b & ~pop) |
                              (skew > (AW+1)'(MAX_SKEW)));
    assign flush  = clear | ~enable | fault;
    assign cmp_fire = pop & ~flush;

    assign armed_a_nx = ~flush & (armed_a | arm_a);
    assign armed_b_nx = ~flush & (armed_b | arm_b);

    assign rd_a    = mem_a[rp_a[AW-1:0]];
    assign rd_b    = mem_b[rp_b[AW-1:0]];
    assign is_mism = |((rd_a ^ rd_b) & cmp_mask);
    assign locked  = (state == RUN);

    always_comb begin
        state_nx = state;
        pop      = (state == RUN) && !empty_a && !empty_b;
        if (flush) begin
            state_nx = SYNC;
        end else begin
            case (state)
                SYNC:    if (armed_a_nx && armed_b_nx) state_nx = RUN;
                RUN:     state_nx = RUN;
                default: state_nx = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state     <= SYNC;
            prev_vs_a <= 1'b0;
            prev_vs_b <= 1'b0;
            armed_a   <= 1'b0;
            armed_b   <= 1'b0;
        end else begin
            state   <= state_nx;
            armed_a <= armed_a_nx;
            armed_b <= armed_b_nx;
            if (a_ce) prev_vs_a <= a_vs;
            if (b_ce) prev_vs_b <= b_vs;
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            wp_a <= '0;
            rp_a <= '0;
            wp_b <= '0;
            rp_b <= '0;
        end else if (flush) begin
            wp_a <= '0;
            rp_a <= '0;
            wp_b <= '0;
            rp_b <= '0;
        end else begin
            if (push_a) wp_a <= wp_a + 1'b1;
            if (push_b) wp_b <= wp_b + 1'b1;
            if (pop) begin
                rp_a <= rp_a + 1'b1;
                rp_b <= rp_b + 1'b1;
            end
        end
    end

    // When full, the write slot equals the read slot; the pop still sees the old word
    always_ff @(posedge clk_sys) begin
        if (push_a && !flush) mem_a[wp_a[AW-1:0]] <= {a_hs, a_vs, a_pix};
        if (push_b && !flush) mem_b[wp_b[AW-1:0]] <= {b_hs, b_vs, b_pix};
    end

    always_comb begin
        x_nx      = x;
        y_nx      = y;
        frame_inc = 1'b0;
        if (rd_a[W-2] && !pa_vs) begin
            x_nx      = '0;
            y_nx      = '0;
            frame_inc = 1'b1;
        end else if (rd_a[W-1] && !pa_hs) begin
            x_nx = '0;
            y_nx = (y == 10'd1023) ? y : y + 10'd1;
        end else begin
            x_nx = (x == 10'd1023) ? x : x + 10'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            mismatch    <= 1'b0;
            mism_count  <= '0;
            frame_count <= '0;
            first_valid <= 1'b0;
            first_x     <= '0;
            first_y     <= '0;
            first_a     <= '0;
            first_b     <= '0;
            overflow    <= 1'b0;
            x           <= '0;
            y           <= '0;
            pa_vs       <= 1'b0;
            pa_hs       <= 1'b0;
        end else if (clear) begin
            mismatch    <= 1'b0;
            mism_count  <= '0;
            frame_count <= '0;
            first_valid <= 1'b0;
            first_x     <= '0;
            first_y     <= '0;
            first_a     <= '0;
            first_b     <= '0;
            overflow    <= 1'b0;
            x           <= '0;
            y           <= '0;
            pa_vs       <= 1'b0;
            pa_hs       <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (fault) overflow <= 1'b1;
            // Forget the last popped syncs so a resync counts its first frame
            if (flush) begin
                pa_vs <= 1'b0;
                pa_hs <= 1'b0;
            end
            if (cmp_fire) begin
                pa_vs <= rd_a[W-2];
                pa_hs <= rd_a[W-1];
                x     <= x_nx;
                y     <= y_nx;
                if (frame_inc) frame_count <= frame_count + 16'd1;
                if (is_mism) begin
                    mismatch <= 1'b1;
                    if (mism_count != 16'hFFFF) mism_count <= mism_count + 16'd1;
                    if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_x     <= x_nx;
                        first_y     <= y_nx;
                        first_a     <= rd_a;
                        first_b     <= rd_b;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vid_lockstep_cmp.sv
`default_nettype none
// ============================================================================
// tb_vid_lockstep_cmp : directed self-checking bench for vid_lockstep_cmp
// Rev 1.0
// ============================================================================
module tb_vid_lockstep_cmp;
    localparam int PIX_W    = 3;
    localparam int CHANNELS = 3;
    localparam int DEPTH    = 16;
    localparam int MAX_SKEW = 12;
    localparam int PW       = PIX_W*CHANNELS;
    localparam int W        = PW + 2;
    localparam int HW       = 40;
    localparam int VH       = 12;
    localparam int FS       = HW*VH;

    logic          clk_sys = 1'b0;
    logic          nRESET, enable, clear;
    logic [W-1:0]  cmp_mask;
    logic          a_ce, b_ce, a_hs, a_vs, b_hs, b_vs;
    logic [PW-1:0] a_pix, b_pix;
    logic          locked, mismatch, first_valid, overflow;
    logic [15:0]   mism_count, frame_count;
    logic [9:0]    first_x, first_y;
    logic [W-1:0]  first_a, first_b;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int p0;

    vid_lockstep_cmp #(
        .PIX_W(PIX_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW)
    ) dut (
        .clk_sys(clk_sys), .nRESET(nRESET), .enable(enable), .clear(clear),
        .cmp_mask(cmp_mask), .a_ce(a_ce), .b_ce(b_ce),
        .a_hs(a_hs), .a_vs(a_vs), .b_hs(b_hs), .b_vs(b_vs),
        .a_pix(a_pix), .b_pix(b_pix),
        .locked(locked), .mismatch(mismatch), .mism_count(mism_count),
        .frame_count(frame_count), .first_valid(first_valid),
        .first_x(first_x), .first_y(first_y), .first_a(first_a), .first_b(first_b),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (mismatch) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Frame of VH lines x HW samples; VSync on lines 0-1, HSync on samples 0-1
    function automatic logic [W-1:0] gen_word(input int k);
        int f, r, ln, s;
        logic [PW-1:0] p;
        if (k < 0) return '0;
        f  = k / FS;
        r  = k % FS;
        ln = r / HW;
        s  = r % HW;
        p  = PW'((ln*7 + s*3 + f*5) & 511);
        return {(s < 2), (ln < 2), p};
    endfunction

    function automatic bit is_flip(input int k);
        return (k == 10*HW+37) || (k == 10*HW+38) || (k == 11*HW+5) || (k == FS+3*HW+3);
    endfunction

    // flip_mode: 0 none, 1 listed B samples, 2 every B sample
    task automatic stream(input int k0, input int n, input int lag, input int period,
                          input int flip_mode);
        for (int k = k0; k < k0 + n; k++) begin
            logic [W-1:0] wa, wb;
            wa = gen_word(k);
            wb = gen_word(k - lag);
            if (flip_mode == 2 || (flip_mode == 1 && is_flip(k - lag))) wb[0] = ~wb[0];
            {a_hs, a_vs, a_pix} = wa;
            {b_hs, b_vs, b_pix} = wb;
            a_ce = 1'b1;
            b_ce = 1'b1;
            tick();
            a_ce = 1'b0;
            b_ce = 1'b0;
            repeat (period - 1) tick();
        end
        repeat (4) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] exp_a;
        nRESET = 1'b0; enable = 1'b0; clear = 1'b0; cmp_mask = '1;
        a_ce = 1'b0; b_ce = 1'b0; a_hs = 1'b0; a_vs = 1'b0; b_hs = 1'b0; b_vs = 1'b0;
        a_pix = '0; b_pix = '0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_locked", locked, 0);
        check("rst_mism", mism_count, 0);
        check("rst_frame", frame_count, 0);
        check("rst_first_valid", first_valid, 0);
        check("rst_overflow", overflow, 0);
        nRESET = 1'b1;
        enable = 1'b1;
        tick();

        // Identical streams, two frames
        stream(0, 2*FS, 0, 2, 0);
        @(negedge clk_sys);
        check("ident_locked", locked, 1);
        check("ident_mism", mism_count, 0);
        check("ident_frames", frame_count, 2);
        check("ident_overflow", overflow, 0);

        // B lags by 5 samples
        pulse_clear();
        stream(0, 2*FS, 5, 2, 0);
        @(negedge clk_sys);
        check("lag5_locked", locked, 1);
        check("lag5_mism", mism_count, 0);
        check("lag5_overflow", overflow, 0);
        check("lag5_frames", frame_count, 2);

        // Four flipped B samples
        pulse_clear();
        p0 = pulses;
        stream(0, 2*FS, 0, 2, 1);
        @(negedge clk_sys);
        exp_a = gen_word(10*HW+37);
        check("flip_mism", mism_count, 4);
        check("flip_pulses", pulses - p0, 4);
        check("flip_first_valid", first_valid, 1);
        check("flip_first_x", first_x, 37);
        check("flip_first_y", first_y, 10);
        check("flip_first_xor", first_a ^ first_b, 1);
        check("flip_first_a", first_a, exp_a);

        // Same flips with bit 0 masked out
        pulse_clear();
        cmp_mask = '1;
        cmp_mask[0] = 1'b0;
        stream(0, 2*FS, 0, 2, 1);
        @(negedge clk_sys);
        check("mask_mism", mism_count, 0);
        check("mask_first_valid", first_valid, 0);
        cmp_mask = '1;

        // B lags by 14: skew fault, then realign with no lag
        pulse_clear();
        stream(0, FS, 14, 2, 0);
        @(negedge clk_sys);
        check("lag14_overflow", overflow, 1);
        check("lag14_unlocked", locked, 0);
        stream(FS, 2*FS, 0, 2, 0);
        @(negedge clk_sys);
        check("resync_locked", locked, 1);
        check("resync_mism", mism_count, 0);
        check("resync_overflow_sticky", overflow, 1);

        // Saturation: every pair mismatches
        p0 = pulses;
        stream(0, 65600, 0, 1, 2);
        @(negedge clk_sys);
        check("sat_mism", mism_count, 32'hFFFF);
        check("sat_pulses", pulses - p0, 65600);
        check("sat_first_x", first_x, 0);
        pulse_clear();
        @(negedge clk_sys);
        check("clr_mism", mism_count, 0);
        check("clr_frames", frame_count, 0);
        check("clr_first_valid", first_valid, 0);
        check("clr_overflow", overflow, 0);
        check("clr_locked", locked, 0);

        // Asynchronous reset mid-line while running
        stream(0, 300, 0, 2, 0);
        @(negedge clk_sys);
        check("pre_rst_locked", locked, 1);
        check("pre_rst_frames", frame_count, 1);
        tick();
        nRESET = 1'b0;
        #1;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_frames", frame_count, 0);
        check("mid_rst_first_valid", first_valid, 0);
        @(negedge clk_sys);
        check("mid_rst_mism", mism_count, 0);
        tick();
        nRESET = 1'b1;
        tick();
        stream(300, FS-300, 0, 2, 0);
        @(negedge clk_sys);
        check("post_rst_no_vs", locked, 0);
        tick();
        {a_hs, a_vs, a_pix} = gen_word(FS);
        {b_hs, b_vs, b_pix} = gen_word(FS);
        a_ce = 1'b1;
        b_ce = 1'b1;
        @(negedge clk_sys);
        check("arm_same_cycle", locked, 0);
        tick();
        a_ce = 1'b0;
        b_ce = 1'b0;
        @(negedge clk_sys);
        check("arm_next_cycle", locked, 1);
        tick();
        stream(FS+1, FS-1, 0, 2, 0);
        @(negedge clk_sys);
        check("post_rst_mism", mism_count, 0);
        check("post_rst_frames", frame_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vid_lockstep_cmp.md
# vid_lockstep_cmp

Lockstep comparator for two independently clocked-enabled video streams sharing `clk_sys`, for example a synchronous ULA model against an asynchronous one. Each stream is sampled on its own clock enable into a skew FIFO. Both streams are aligned on the VSync rising edge, then compared sample by sample under a mask. The block counts mismatches and latches the frame position and data of the first one. It sits in the bench/debug layer beside the video models and drives nothing in the machine.

## Interface
- `PIX_W`, 3, bits per colour channel.
- `CHANNELS`, 3, number of colour channels.
- `DEPTH`, 16, FIFO depth per stream; must be a power of 2, ≥4.
- `MAX_SKEW`, 12, maximum allowed occupancy difference between the two FIFOs; must be < `DEPTH`.
- Derived: `W` = `CHANNELS*PIX_W+2`. Sample word is {HSync, VSync, pixels}.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock.
- `nRESET`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no pushes occur and the FSM holds in SYNC.
- `clear`  in  1  synchronous pulse: clears counters, flags and latches, empties both FIFOs, returns to SYNC.
- `cmp_mask`  in  W  a 1 bit means that bit is compared.
- `a_ce`, `b_ce`  in  1  per-stream sample enable.
- `a_hs`, `a_vs`, `b_hs`, `b_vs`  in  1  stream syncs.
- `a_pix`, `b_pix`  in  CHANNELS*PIX_W  stream pixel data.
- `locked`  out  1  FSM is in RUN.
- `mismatch`  out  1  one-cycle pulse per mismatching pair.
- `mism_count`  out  16  saturating mismatch count.
- `frame_count`  out  16  wrapping count of compared frames.
- `first_valid`  out  1  first-mismatch latch is loaded.
- `first_x`, `first_y`  out  10  position of the first mismatch.
- `first_a`, `first_b`  out  W  sample words of the first mismatch.
- `overflow`  out  1  sticky flag: FIFO overflow or skew violation seen.

## Operation
- All outputs and state reset to 0; the FSM resets to SYNC.
- Per stream, a VS-edge detector is evaluated only on that stream's ce. `armed_x` sets on the ce where vs=1 and the previous sampled vs=0; that sample is the first one pushed. Every following ce pushes while `armed_x`=1.
- FSM states:
  - SYNC: pops are disabled. Go to RUN when `armed_a & armed_b`.
  - RUN: when both FIFOs are non-empty, pop one word from each and compare them.
- Fault (overflow), checked in RUN or SYNC:
  - Trigger: a push into a full FIFO with no pop from it in the same cycle, or |occ_a − occ_b| > `MAX_SKEW`.
  - Response: set `overflow`, flush both FIFOs, clear both `armed` bits, enter SYNC.
  - Counters and latches are kept.
- Compare: `diff` = (wa ^ wb) & `cmp_mask`. A non-zero `diff` is a mismatch.
- Position counters advance on each popped pair, using the A-side word only:
  - A vs rising edge (relative to the previous popped A word): x=0, y=0, `frame_count`+1.
  - Otherwise, A hs rising edge: x=0, y+1 (saturates at 1023).
  - Otherwise: x+1 (saturates at 1023).
  - The reported position is the value after this update.
- First mismatch: on the first mismatch while `first_valid`=0, latch x, y, wa and wb, and set `first_valid`.
- `mism_count` increments on every mismatch and saturates at 0xFFFF.
- `clear` has priority over all other actions in its cycle. `enable`=0 forces SYNC, clears the `armed` bits and flushes the FIFOs on entry.

## Timing
- FIFO write occurs on the cycle of the ce. A word is poppable from the next cycle.
- Simultaneous push and pop on one FIFO is legal at any occupancy, including full (no overflow) and empty (the pop is suppressed and the push lands).
- The compare is registered. `mismatch`, the counter updates and the latches appear 1 cycle after the pop cycle.
- Latency from the later stream's ce to the compare result is 2 cycles when both FIFOs were empty.
- `locked` rises 1 cycle after the second arming. It falls 1 cycle after a fault, `clear`, or `enable` deassertion.
- A fault and a pop in the same cycle: the pop is discarded and not compared.
- `nRESET` asserted mid-frame: all state clears immediately. After release, the block waits for fresh VS edges on both streams.

## Test plan
- Identical streams, `a_ce`=`b_ce` every 8 cycles, 2 frames of 448×312, full mask → `locked`=1, `mism_count`=0, `frame_count`=2, `overflow`=0.
- B lags A by 5 samples, identical content → still 0 mismatches. Occupancy difference stays at 5, so no overflow with `MAX_SKEW`=12.
- B pixel bit 0 flipped at line 10, sample 37, plus at 3 later samples → `mism_count`=4, `first_valid`=1, `first_x`=37, `first_y`=10, `first_a`^`first_b`=1. `cmp_mask` with bit 0 cleared → count stays 0.
- B lags A by 14 samples → `overflow`=1 and `locked` drops. After the next VS on both streams, `locked`=1 again and comparison resumes with 0 mismatches.
- Force 70000 mismatches → `mism_count`=0xFFFF and holds. `clear` pulse → all counters and flags 0, FSM in SYNC.
- Assert `nRESET` mid-line in RUN → all outputs 0 while asserted. After release, `locked` stays 0 until both streams present a VS rising edge.
